cam_vip_packetizer: RTL and testbench

Converts the raw camera-timed pixel stream (fval/lval/data, already in the system clock domain after the camera capture stage) into Avalon-ST Video packets for the VIP pipeline. Each frame becomes one control packet followed by one video data packet. A small FIFO absorbs downstream backpressure. Sits directly upstream of the image-processing / frame-buffer chain that ends at the clocked-video output.

---
 rtl/cam_vip_packetizer_pkg.sv | 40 ++++
 rtl/cam_vip_packetizer_fifo.sv | 52 +++++
 rtl/cam_vip_packetizer.sv | 218 +++++++++++++++++++++
 tb/tb_cam_vip_packetizer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_vip_packetizer_pkg.sv
// Shared types and constants for the camera-to-VIP packetizer.
package cam_vip_pkg;

  // Beat width: three 8-bit symbols carried in parallel.
  localparam int VIP_PIX_W = 24;

  // Avalon-ST Video packet type identifiers.
  localparam logic [3:0] VIP_TYPE_CTRL = 4'hF;
  localparam logic [3:0] VIP_TYPE_DATA = 4'h0;

  // Number of beats in control header plus data-packet type beat.
  localparam int VIP_HDR_BEATS = 5;

  typedef enum logic [2:0] {
    W_IDLE,
    W_HDR,
    W_PIX,
    W_PAD,
    W_EOP,
    W_DONE
  } wr_state_e;

  typedef struct packed {
    logic                 sop;
    logic                 eop;
    logic [VIP_PIX_W-1:0] data;
  } vip_beat_t;

  // Pixels per frame. The 32-bit product covers the full 16-bit x 16-bit range.
  function automatic logic [31:0] total_pixels(input int unsigned w, input int unsigned h);
    return 32'(w * h);
  endfunction

  // Control packet symbols: each nibble sits in the low half of its 8-bit symbol.
  function automatic logic [23:0] ctrl_symbols(input logic [3:0] s0, input logic [3:0] s1,
                                               input logic [3:0] s2);
    return {4'h0, s2, 4'h0, s1, 4'h0, s0};
  endfunction

endpackage

// File: rtl/cam_vip_packetizer_fifo.sv
// Single-clock show-ahead FIFO: the head entry is always presented on rd_data.
module vid_sync_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  // Extra pointer bit distinguishes full from empty when the indices match.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_wr    = wr_en & ~full;
    do_rd    = rd_en & ~empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
    rd_data  = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer registers; reset empties the FIFO without touching storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array, written only when there is room.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/cam_vip_packetizer.sv
// Turns fval/lval/data camera timing into one control packet plus one video
// packet per frame, buffered through a small beat FIFO.
module cam_vip_packetizer
  import cam_vip_pkg::*;
#(
  parameter int PIX_W      = VIP_PIX_W,
  parameter int FRAME_W    = 640,
  parameter int FRAME_H    = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_fval,
  input  logic             in_lval,
  input  logic [PIX_W-1:0] in_data,
  output logic [PIX_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sop,
  output logic             out_eop,
  input  logic             status_clr,
  output logic             overflow,
  output logic             hdr_err,
  output logic             short_frame,
  output logic             long_frame,
  output logic [15:0]      frame_cnt
);

  localparam int          BEAT_W = $bits(vip_beat_t);
  localparam logic [31:0] TOTAL  = total_pixels(FRAME_W, FRAME_H);
  localparam logic [31:0] LAST   = TOTAL - 32'd1;
  localparam logic [15:0] W16    = 16'(FRAME_W);
  localparam logic [15:0] H16    = 16'(FRAME_H);
  localparam logic [23:0] HDR1   = ctrl_symbols(W16[15:12], W16[11:8], W16[7:4]);
  localparam logic [23:0] HDR2   = ctrl_symbols(W16[3:0], H16[15:12], H16[11:8]);
  localparam logic [23:0] HDR3   = ctrl_symbols(H16[7:4], H16[3:0], 4'h0);

  wr_state_e   state_q, state_d;
  logic [2:0]  hdr_idx_q, hdr_idx_d;
  logic [31:0] pix_cnt_q, pix_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        fval_q, fval_d;
  logic        overflow_q, overflow_d;
  logic        hdr_err_q, hdr_err_d;
  logic        short_q, short_d;
  logic        long_q, long_d;

  logic        fval_rise, pixel, at_last;
  logic        ovf_set, hdr_set, short_set, long_set;
  logic        wr_en, fifo_full, fifo_empty;
  vip_beat_t   wr_beat, rd_beat;
  logic [BEAT_W-1:0] rd_vec;

  // Writer FSM: next state, counters, FIFO write beat and sticky-flag events.
  always_comb begin
    state_d     = state_q;
    hdr_idx_d   = hdr_idx_q;
    pix_cnt_d   = pix_cnt_q;
    frame_cnt_d = frame_cnt_q;
    fval_d      = in_fval;
    wr_en       = 1'b0;
    wr_beat     = '0;
    ovf_set     = 1'b0;
    hdr_set     = 1'b0;
    short_set   = 1'b0;
    long_set    = 1'b0;
    fval_rise   = in_fval & ~fval_q;
    pixel       = in_fval & in_lval;
    at_last     = (pix_cnt_q >= LAST);

    case (state_q)
      W_IDLE: begin
        if (fval_rise) begin
          state_d   = W_HDR;
          hdr_idx_d = 3'd0;
          pix_cnt_d = '0;
        end
      end
      W_HDR: begin
        if (pixel) begin
          pix_cnt_d = pix_cnt_q + 32'd1;
          hdr_set   = 1'b1;
        end
        if (!fifo_full) begin
          wr_en = 1'b1;
          case (hdr_idx_q)
            3'd0: begin
              wr_beat.sop  = 1'b1;
              wr_beat.data = {20'h0, VIP_TYPE_CTRL};
            end
            3'd1: wr_beat.data = HDR1;
            3'd2: wr_beat.data = HDR2;
            3'd3: begin
              wr_beat.data = HDR3;
              wr_beat.eop  = 1'b1;
            end
            default: begin
              wr_beat.sop  = 1'b1;
              wr_beat.data = {20'h0, VIP_TYPE_DATA};
            end
          endcase
          if (hdr_idx_q == 3'(VIP_HDR_BEATS - 1)) begin
            state_d = W_PIX;
          end else begin
            hdr_idx_d = hdr_idx_q + 3'd1;
          end
        end
      end
      W_PIX: begin
        if (!in_fval) begin
          short_set = (pix_cnt_q < TOTAL);
          state_d   = (pix_cnt_q < TOTAL) ? W_PAD : W_EOP;
        end else if (pixel) begin
          pix_cnt_d = pix_cnt_q + 32'd1;
          if (fifo_full) begin
            ovf_set = 1'b1;
            if (at_last) begin
              state_d = W_EOP;
            end
          end else begin
            wr_en        = 1'b1;
            wr_beat.data = in_data;
            wr_beat.eop  = at_last;
            if (at_last) begin
              frame_cnt_d = frame_cnt_q + 16'd1;
              state_d     = W_DONE;
            end
          end
        end
      end
      W_PAD: begin
        if (!fifo_full) begin
          wr_en       = 1'b1;
          wr_beat.eop = at_last;
          pix_cnt_d   = pix_cnt_q + 32'd1;
          if (at_last) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = W_IDLE;
          end
        end
      end
      W_EOP: begin
        if (!fifo_full) begin
          wr_en       = 1'b1;
          wr_beat.eop = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = in_fval ? W_DONE : W_IDLE;
        end
      end
      W_DONE: begin
        long_set = pixel;
        if (!in_fval) begin
          state_d = W_IDLE;
        end
      end
      default: state_d = W_IDLE;
    endcase

    overflow_d = (overflow_q & ~status_clr) | ovf_set;
    hdr_err_d  = (hdr_err_q  & ~status_clr) | hdr_set;
    short_d    = (short_q    & ~status_clr) | short_set;
    long_d     = (long_q     & ~status_clr) | long_set;
  end

  // Writer state, counters and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= W_IDLE;
      hdr_idx_q   <= '0;
      pix_cnt_q   <= '0;
      frame_cnt_q <= '0;
      fval_q      <= 1'b0;
      overflow_q  <= 1'b0;
      hdr_err_q   <= 1'b0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_idx_q   <= hdr_idx_d;
      pix_cnt_q   <= pix_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      fval_q      <= fval_d;
      overflow_q  <= overflow_d;
      hdr_err_q   <= hdr_err_d;
      short_q     <= short_d;
      long_q      <= long_d;
    end
  end

  vid_sync_fifo #(
    .WIDTH(BEAT_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_data(wr_beat),
    .rd_en  (out_valid & out_ready),
    .rd_data(rd_vec),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Output side; payload is forced to zero while no beat is presented.
  always_comb begin
    rd_beat     = vip_beat_t'(rd_vec);
    out_valid   = ~fifo_empty;
    out_data    = out_valid ? rd_beat.data : '0;
    out_sop     = out_valid & rd_beat.sop;
    out_eop     = out_valid & rd_beat.eop;
    overflow    = overflow_q;
    hdr_err     = hdr_err_q;
    short_frame = short_q;
    long_frame  = long_q;
    frame_cnt   = frame_cnt_q;
  end

endmodule

// File: tb/tb_cam_vip_packetizer.sv
// Bench for cam_vip_packetizer: directed frame scenarios with random pixel data
// and gaps, checked against a frame-level model of the packet contents.
module tb_cam_vip_packetizer;

  localparam int PIX_W = 24;
  localparam int FW    = 4;
  localparam int FH    = 2;
  localparam int DEPTH = 8;
  localparam int TOTAL = FW * FH;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_fval = 1'b0;
  logic             in_lval = 1'b0;
  logic [PIX_W-1:0] in_data = '0;
  logic             out_ready = 1'b1;
  logic             status_clr = 1'b0;
  logic [PIX_W-1:0] out_data;
  logic             out_valid, out_sop, out_eop;
  logic             overflow, hdr_err, short_frame, long_frame;
  logic [15:0]      frame_cnt;

  int checks_total  = 0;
  int checks_passed = 0;

  logic toggle_ready = 1'b0;
  logic [25:0]      got_q[$];
  logic [25:0]      exp_q[$];
  logic [PIX_W-1:0] sent_q[$];
  logic [15:0]      exp_frames = '0;
  logic exp_ovf = 1'b0, exp_hdr = 1'b0, exp_short = 1'b0, exp_long = 1'b0;

  logic        prev_stall = 1'b0;
  logic [25:0] prev_beat  = '0;

  always #5 clk = ~clk;

  cam_vip_packetizer #(
    .PIX_W(PIX_W), .FRAME_W(FW), .FRAME_H(FH), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .in_fval(in_fval), .in_lval(in_lval), .in_data(in_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop),
    .status_clr(status_clr),
    .overflow(overflow), .hdr_err(hdr_err),
    .short_frame(short_frame), .long_frame(long_frame),
    .frame_cnt(frame_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks_total++;
    assert (observed === expected) begin
      checks_passed++;
    end else begin
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of camera inputs; returns #1 after the next rising edge.
  task automatic applyStimulus(input logic fv, input logic lv, input logic [PIX_W-1:0] d,
                               input logic clr);
    in_fval    = fv;
    in_lval    = lv;
    in_data    = d;
    status_clr = clr;
    if (toggle_ready) out_ready = ~out_ready;
    @(posedge clk);
    #1;
    status_clr = 1'b0;
  endtask

  // Capture every accepted beat as {sop, eop, data}.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) got_q.push_back({out_sop, out_eop, out_data});
  end

  // A stalled beat must be presented unchanged on the following cycle.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall)
        checkOutput("stall_hold", {5'b0, out_valid, out_sop, out_eop, out_data},
                    {5'b0, 1'b1, prev_beat});
      prev_stall <= out_valid && !out_ready;
      prev_beat  <= {out_sop, out_eop, out_data};
    end
  end

  function automatic logic [23:0] sym3(input int a, input int b, input int c);
    logic [23:0] r;
    r = 24'((a % 16) + (b % 16) * 256 + (c % 16) * 65536);
    return r;
  endfunction

  // Control packet (type F, width/height nibbles, progressive) then data type beat.
  task automatic expectHeader();
    exp_q.push_back({2'b10, 24'h00000F});
    exp_q.push_back({2'b00, sym3(FW / 4096, FW / 256, FW / 16)});
    exp_q.push_back({2'b00, sym3(FW, FH / 4096, FH / 256)});
    exp_q.push_back({2'b01, sym3(FH / 16, FH, 0)});
    exp_q.push_back({2'b10, 24'h000000});
  endtask

  // Frame-level model: first TOTAL counted pixels form the payload, extras are
  // dropped, missing pixels are padded with zeros; eop sits on pixel TOTAL-1.
  task automatic buildModel(input int early);
    int cnt;
    cnt = early;
    expectHeader();
    if (early != 0) exp_hdr = 1'b1;
    foreach (sent_q[i]) begin
      if (cnt < TOTAL) exp_q.push_back({1'b0, (cnt == TOTAL - 1), sent_q[i]});
      else exp_long = 1'b1;
      cnt++;
    end
    if (cnt < TOTAL) exp_short = 1'b1;
    while (cnt < TOTAL) begin
      exp_q.push_back({1'b0, (cnt == TOTAL - 1), 24'h0});
      cnt++;
    end
    exp_frames++;
  endtask

  task automatic runFrame(input int n_pix, input int early, input int gap_min,
                          input int gap_max, input int clr_at, input bit seq);
    logic [PIX_W-1:0] d;
    sent_q.delete();
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, (early != 0 && i == 0), 24'hABCDEF, 1'b0);
    for (int i = 0; i < n_pix; i++) begin
      int gap;
      gap = gap_min + int'($urandom_range(gap_max - gap_min));
      repeat (gap) applyStimulus(1'b1, 1'b0, '0, 1'b0);
      d = seq ? PIX_W'(i + 1) : PIX_W'($urandom);
      sent_q.push_back(d);
      applyStimulus(1'b1, 1'b1, d, (i == clr_at));
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic compareFrame(input string tag);
    int budget;
    budget = 0;
    repeat (12) applyStimulus(1'b0, 1'b0, '0, 1'b0);
    while (got_q.size() < exp_q.size() && budget < 200) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      budget++;
    end
    checkOutput($sformatf("%s_len", tag), got_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < got_q.size())
        checkOutput($sformatf("%s_beat%0d", tag, i), {6'b0, got_q[i]}, {6'b0, exp_q[i]});
    checkOutput($sformatf("%s_flags", tag), {overflow, hdr_err, short_frame, long_frame},
                {exp_ovf, exp_hdr, exp_short, exp_long});
    checkOutput($sformatf("%s_frame_cnt", tag), frame_cnt, exp_frames);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic clearFlags();
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    exp_ovf = 1'b0; exp_hdr = 1'b0; exp_short = 1'b0; exp_long = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs",
                {out_valid, out_sop, out_eop, overflow, hdr_err, short_frame, long_frame},
                7'b0);
    checkOutput("reset_data_cnt", {out_data, frame_cnt[7:0]}, 32'h0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, 1'b0);

    // Nominal frame with pixels 1..8 and an always-ready sink.
    runFrame(TOTAL, 0, 0, 0, -1, 1'b1);
    buildModel(0);
    compareFrame("nominal");

    // Randomized frame lengths, pixel gaps and data.
    for (int f = 0; f < 6; f++) begin
      runFrame(int'($urandom_range(TOTAL + 3)), 0, 0, 3, -1, 1'b0);
      buildModel(0);
      compareFrame($sformatf("rand%0d", f));
      clearFlags();
    end

    runFrame(5, 0, 0, 1, -1, 1'b0);
    buildModel(0);
    compareFrame("short");
    clearFlags();

    runFrame(TOTAL + 2, 0, 0, 0, -1, 1'b0);
    buildModel(0);
    compareFrame("long");
    clearFlags();

    runFrame(TOTAL - 1, 1, 0, 0, -1, 1'b0);
    buildModel(1);
    compareFrame("hdr_early");
    clearFlags();

    // Sink ready alternates every cycle; pixels every other cycle.
    toggle_ready = 1'b1;
    runFrame(TOTAL, 0, 1, 1, -1, 1'b1);
    buildModel(0);
    compareFrame("toggle");
    toggle_ready = 1'b0;
    out_ready    = 1'b1;

    // Sink stalled for the whole frame: only DEPTH-5 pixels fit behind the
    // header, the rest overflow, and the dropped final pixel forces a lone eop.
    // status_clr lands on the last dropped pixel, so overflow must survive.
    out_ready = 1'b0;
    runFrame(TOTAL, 0, 0, 0, TOTAL - 1, 1'b0);
    checkOutput("ovf_clr_same_cycle", overflow, 1'b1);
    checkOutput("ovf_cnt_held", frame_cnt, exp_frames);
    expectHeader();
    for (int i = 0; i < DEPTH - 5; i++) exp_q.push_back({2'b00, sent_q[i]});
    exp_q.push_back({2'b01, 24'h0});
    exp_ovf = 1'b1;
    exp_frames++;
    out_ready = 1'b1;
    compareFrame("overflow");
    clearFlags();
    checkOutput("clr_flags", {overflow, hdr_err, short_frame, long_frame}, 4'b0);

    // Reset in the middle of the pixel phase abandons the packet.
    out_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, PIX_W'($urandom), 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("midreset_valid", {out_valid, out_sop, out_eop}, 3'b0);
    checkOutput("midreset_cnt", frame_cnt, 16'h0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    reset      = 1'b0;
    out_ready  = 1'b1;
    exp_frames = '0;
    got_q.delete();
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    runFrame(TOTAL, 0, 0, 2, -1, 1'b0);
    buildModel(0);
    compareFrame("after_reset");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
